// File: rtl/ddr_dbi_lane_pipe.sv
// Multi-lane, multi-phase DBI encoder/decoder with DC/AC egress modes,
// a programmable 0..MAX_PIPE output delay and a saturating inversion counter.
module ddr_dbi_lane_pipe #(
    parameter int WIDTH    = 8,
    parameter int NUM_PH   = 4,
    parameter int NUM_LANE = 2,
    parameter int MAX_PIPE = 2,
    parameter bit EGRESS   = 1'b1,
    parameter int CWIDTH   = 16,
    parameter int PWIDTH   = $clog2(MAX_PIPE+1)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_dbi_en,
    input  logic                             i_dbi_ones,
    input  logic                             i_ac_mode,
    input  logic [PWIDTH-1:0]                i_pipe_stages,
    input  logic [WIDTH-1:0]                 i_dbi_mask,
    input  logic                             i_cnt_clr,
    input  logic                             i_valid,
    input  logic [NUM_LANE*NUM_PH*WIDTH-1:0] i_sdr,
    input  logic [NUM_LANE*NUM_PH-1:0]       i_sdr_dbi,
    output logic                             o_valid,
    output logic [NUM_LANE*NUM_PH*WIDTH-1:0] o_sdr,
    output logic [NUM_LANE*NUM_PH-1:0]       o_sdr_dbi,
    output logic [CWIDTH-1:0]                o_inv_cnt
);
    localparam int NW  = NUM_LANE * NUM_PH;
    localparam int DW  = NW * WIDTH;
    localparam int LW  = NUM_PH * WIDTH;
    localparam int MCW = $clog2(WIDTH + 1);
    localparam int FCW = $clog2(NW + 1);

    function automatic logic [MCW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [MCW-1:0] n;
        n = '0;
        for (int b = 0; b < WIDTH; b++) n = n + MCW'(v[b]);
        return n;
    endfunction

    logic [WIDTH-1:0] unmask;
    logic [MCW-1:0]   thresh;
    logic [DW-1:0]    enc_data;
    logic [NW-1:0]    enc_flag;

    assign unmask = ~i_dbi_mask;
    assign thresh = popcnt(unmask) >> 1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANE; gi++) begin : g_lane
            logic [WIDTH-1:0]  hist_q;
            logic [WIDTH-1:0]  hist_d;
            logic [LW-1:0]     lane_data;
            logic [NUM_PH-1:0] lane_flag;
            logic [WIDTH-1:0]  ref_w;
            logic [WIDTH-1:0]  word_w;
            logic [WIDTH-1:0]  cand_w;

            // AC reference chains phase to phase: each phase compares with the
            // previous transmitted phase, phase 0 with the lane history.
            always_comb begin
                ref_w     = hist_q;
                lane_data = '0;
                lane_flag = '0;
                word_w    = '0;
                cand_w    = '0;
                for (int p = 0; p < NUM_PH; p++) begin
                    word_w = i_sdr[(gi*NUM_PH+p)*WIDTH +: WIDTH];
                    if (EGRESS) begin
                        if (i_ac_mode)
                            cand_w = word_w ^ ref_w;
                        else if (i_dbi_ones)
                            cand_w = word_w;
                        else
                            cand_w = ~word_w;
                        lane_flag[p] = i_dbi_en && (popcnt(unmask & cand_w) > thresh);
                    end else begin
                        lane_flag[p] = i_dbi_en & i_sdr_dbi[gi*NUM_PH+p];
                    end
                    ref_w = word_w ^ ({WIDTH{lane_flag[p]}} & unmask);
                    lane_data[p*WIDTH +: WIDTH] = ref_w;
                end
                hist_d = i_valid ? ref_w : hist_q;
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) hist_q <= '0;
                else       hist_q <= hist_d;
            end

            assign enc_data[gi*LW +: LW]         = lane_data;
            assign enc_flag[gi*NUM_PH +: NUM_PH] = lane_flag;
        end
    endgenerate

    // Inversion counter: clear wins over increment, sum saturates.
    logic [FCW-1:0]        flag_sum;
    logic [CWIDTH+FCW-1:0] cnt_sum;
    logic [CWIDTH-1:0]     cnt_q;
    logic [CWIDTH-1:0]     cnt_d;

    always_comb begin
        flag_sum = '0;
        for (int i = 0; i < NW; i++) flag_sum = flag_sum + FCW'(enc_flag[i]);
        cnt_sum = (CWIDTH+FCW)'(cnt_q) + (CWIDTH+FCW)'(flag_sum);
        cnt_d   = cnt_q;
        if (i_cnt_clr)
            cnt_d = '0;
        else if (i_valid)
            cnt_d = (|cnt_sum[CWIDTH +: FCW]) ? {CWIDTH{1'b1}} : cnt_sum[CWIDTH-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_inv_cnt = cnt_q;

    logic          st_valid [MAX_PIPE];
    logic [DW-1:0] st_data  [MAX_PIPE];
    logic [NW-1:0] st_flag  [MAX_PIPE];

    generate
        for (gi = 0; gi < MAX_PIPE; gi++) begin : g_stage
            logic          valid_q, valid_d;
            logic [DW-1:0] data_q, data_d;
            logic [NW-1:0] flag_q, flag_d;

            if (gi == 0) begin : g_first
                assign valid_d = i_valid;
                assign data_d  = enc_data;
                assign flag_d  = enc_flag;
            end else begin : g_next
                assign valid_d = st_valid[gi-1];
                assign data_d  = st_data[gi-1];
                assign flag_d  = st_flag[gi-1];
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    flag_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                    flag_q  <= flag_d;
                end
            end

            assign st_valid[gi] = valid_q;
            assign st_data[gi]  = data_q;
            assign st_flag[gi]  = flag_q;
        end
    endgenerate

    logic [PWIDTH-1:0] sel;

    always_comb begin
        sel       = (i_pipe_stages > PWIDTH'(MAX_PIPE)) ? PWIDTH'(MAX_PIPE) : i_pipe_stages;
        o_valid   = i_valid;
        o_sdr     = enc_data;
        o_sdr_dbi = enc_flag;
        for (int s = 1; s <= MAX_PIPE; s++) begin
            if (sel == PWIDTH'(s)) begin
                o_valid   = st_valid[s-1];
                o_sdr     = st_data[s-1];
                o_sdr_dbi = st_flag[s-1];
            end
        end
    end
endmodule

// File: tb/tb_ddr_dbi_lane_pipe.sv
// Bench for ddr_dbi_lane_pipe: an egress instance (4-bit counter) and an
// ingress instance share stimulus and are checked against a behavioural model.
module tb_ddr_dbi_lane_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, ones = 1'b0, ac = 1'b0, clr = 1'b0, valid = 1'b0;
    logic [1:0]  stages = 2'd2;
    logic [7:0]  mask = 8'h00;
    logic [63:0] sdr = '0;
    logic [7:0]  sdr_dbi = '0;

    logic        e_valid, n_valid;
    logic [63:0] e_sdr, n_sdr;
    logic [7:0]  e_dbi, n_dbi;
    logic [3:0]  e_cnt;
    logic [15:0] n_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ddr_dbi_lane_pipe #(.WIDTH(8), .NUM_PH(4), .NUM_LANE(2), .MAX_PIPE(2),
                        .EGRESS(1'b1), .CWIDTH(4)) u_egr (
        .i_clk(clk), .i_rst(rst), .i_dbi_en(en), .i_dbi_ones(ones),
        .i_ac_mode(ac), .i_pipe_stages(stages), .i_dbi_mask(mask),
        .i_cnt_clr(clr), .i_valid(valid), .i_sdr(sdr), .i_sdr_dbi(sdr_dbi),
        .o_valid(e_valid), .o_sdr(e_sdr), .o_sdr_dbi(e_dbi), .o_inv_cnt(e_cnt));

    ddr_dbi_lane_pipe #(.WIDTH(8), .NUM_PH(4), .NUM_LANE(2), .MAX_PIPE(2),
                        .EGRESS(1'b0), .CWIDTH(16)) u_ing (
        .i_clk(clk), .i_rst(rst), .i_dbi_en(en), .i_dbi_ones(ones),
        .i_ac_mode(ac), .i_pipe_stages(stages), .i_dbi_mask(mask),
        .i_cnt_clr(clr), .i_valid(valid), .i_sdr(sdr), .i_sdr_dbi(sdr_dbi),
        .o_valid(n_valid), .o_sdr(n_sdr), .o_sdr_dbi(n_dbi), .o_inv_cnt(n_cnt));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        v;
        logic [63:0] d;
        logic [7:0]  f;
    } beat_t;

    beat_t      e_cur, n_cur, exp_e, exp_n;
    beat_t      e_line [2];
    beat_t      n_line [2];
    logic [7:0] m_hist [2];
    logic [7:0] pend_hist [2];
    logic [3:0] m_ecnt;
    logic [15:0] m_ncnt;
    logic [7:0] prev_w, w_w;
    logic       ef, nf;
    int         sc, nbits, thr;

    // Expected outputs are derived each cycle from the current inputs and the
    // model's delay line, then compared with both DUTs.
    always @(negedge clk) begin
        thr = $countones(~mask) / 2;
        for (int l = 0; l < 2; l++) begin
            prev_w = m_hist[l];
            for (int p = 0; p < 4; p++) begin
                w_w = sdr[(l*4+p)*8 +: 8];
                if (ac) nbits = $countones((w_w ^ prev_w) & ~mask);
                else    nbits = $countones((ones ? w_w : ~w_w) & ~mask);
                ef = en && (nbits > thr);
                prev_w = ef ? (w_w ^ ~mask) : w_w;
                e_cur.d[(l*4+p)*8 +: 8] = prev_w;
                e_cur.f[l*4+p] = ef;
                nf = en && sdr_dbi[l*4+p];
                n_cur.d[(l*4+p)*8 +: 8] = nf ? (w_w ^ ~mask) : w_w;
                n_cur.f[l*4+p] = nf;
            end
            pend_hist[l] = prev_w;
        end
        e_cur.v = valid;
        n_cur.v = valid;
        sc = (stages > 2'd2) ? 2 : int'(stages);
        exp_e = (sc == 0) ? e_cur : e_line[sc-1];
        exp_n = (sc == 0) ? n_cur : n_line[sc-1];
        if (!rst) begin
            check("egr_valid", 64'(e_valid), 64'(exp_e.v));
            check("egr_sdr",   e_sdr,        exp_e.d);
            check("egr_dbi",   64'(e_dbi),   64'(exp_e.f));
            check("egr_cnt",   64'(e_cnt),   64'(m_ecnt));
            check("ing_valid", 64'(n_valid), 64'(exp_n.v));
            check("ing_sdr",   n_sdr,        exp_n.d);
            check("ing_dbi",   64'(n_dbi),   64'(exp_n.f));
            check("ing_cnt",   64'(n_cnt),   64'(m_ncnt));
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_line <= '{default: '0};
            n_line <= '{default: '0};
            m_hist <= '{default: '0};
            m_ecnt <= '0;
            m_ncnt <= '0;
        end else begin
            e_line[1] <= e_line[0];
            e_line[0] <= e_cur;
            n_line[1] <= n_line[0];
            n_line[0] <= n_cur;
            if (valid) m_hist <= pend_hist;
            if (clr) begin
                m_ecnt <= '0;
                m_ncnt <= '0;
            end else if (valid) begin
                m_ecnt <= ((int'(m_ecnt) + $countones(e_cur.f)) > 15) ? 4'hF
                          : 4'(int'(m_ecnt) + $countones(e_cur.f));
                m_ncnt <= ((int'(m_ncnt) + $countones(n_cur.f)) > 65535) ? 16'hFFFF
                          : 16'(int'(m_ncnt) + $countones(n_cur.f));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        clr   = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_egr_valid", 64'(e_valid), 64'd0);
        check("rst_egr_sdr",   e_sdr,        64'd0);
        check("rst_egr_cnt",   64'(e_cnt),   64'd0);
        check("rst_ing_valid", 64'(n_valid), 64'd0);
        rst = 1'b0;
        step();

        // AC chain from reset history, then history carried to the next beat
        stages = 2'd0; ac = 1'b1; en = 1'b1; ones = 1'b1; mask = 8'h00;
        sdr = 64'h0000_0000_0F00_FFFF; valid = 1'b1;
        #1;
        check("ac_chain_sdr", e_sdr, 64'h0000_0000_0F00_0000);
        check("ac_chain_dbi", 64'(e_dbi), 64'h03);
        step();
        check("ac_cnt1", 64'(e_cnt), 64'd2);
        sdr = 64'h0000_0000_0000_00F0;
        #1;
        check("ac_hist_sdr", e_sdr, 64'h0000_0000_0000_000F);
        check("ac_hist_dbi", 64'(e_dbi), 64'h01);
        step();
        check("ac_cnt2", 64'(e_cnt), 64'd3);
        idle(2);

        // DC ones, no mask; ingress decode via flags
        ac = 1'b0; sdr_dbi = 8'hFF;
        sdr = {8{8'hF8}}; valid = 1'b1;
        #1;
        check("dc_f8_sdr", e_sdr, {8{8'h07}});
        check("dc_f8_dbi", 64'(e_dbi), 64'hFF);
        step();
        check("dc_cnt", 64'(e_cnt), 64'd11);
        sdr = {8{8'h07}};
        #1;
        check("ing_07_sdr", n_sdr, {8{8'hF8}});
        check("dc_07_dbi", 64'(e_dbi), 64'h00);
        step();
        sdr = {8{8'hF0}};
        #1;
        check("dc_f0_sdr", e_sdr, {8{8'hF0}});
        check("dc_f0_dbi", 64'(e_dbi), 64'h00);
        step();
        idle(2);

        // DC with bit 7 masked, then counter saturation and clear priority
        mask = 8'h80; sdr = {8{8'hF8}}; valid = 1'b1;
        #1;
        check("mask_sdr", e_sdr, {8{8'h87}});
        check("mask_dbi", 64'(e_dbi), 64'hFF);
        step();
        check("cnt_sat", 64'(e_cnt), 64'd15);
        clr = 1'b1;
        step();
        check("cnt_clr_prio", 64'(e_cnt), 64'd0);
        clr = 1'b0;
        step();
        check("cnt_8", 64'(e_cnt), 64'd8);
        step();
        check("cnt_sat2", 64'(e_cnt), 64'd15);
        idle(2);

        // Pipeline latency at 2 stages and clamped 3 stages
        mask = 8'h00; en = 1'b0;
        for (int k = 2; k <= 3; k++) begin
            stages = 2'(k);
            idle(2);
            sdr = 64'h0123_4567_89AB_CDEF; valid = 1'b1;
            step();
            valid = 1'b0; sdr = '0;
            check("lat_early", 64'(e_valid), 64'd0);
            step();
            check("lat_valid", 64'(e_valid), 64'd1);
            check("lat_sdr", e_sdr, 64'h0123_4567_89AB_CDEF);
            step();
            check("lat_late", 64'(e_valid), 64'd0);
        end
        en = 1'b1;

        // Reset with two beats in flight; history must restart from zero
        stages = 2'd2; ac = 1'b1;
        idle(2);
        sdr = {8{8'h3C}}; valid = 1'b1;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", 64'(e_valid), 64'd0);
        check("rst_mid_sdr",   e_sdr,        64'd0);
        check("rst_mid_cnt",   64'(e_cnt),   64'd0);
        step();
        #2 rst = 1'b0;
        stages = 2'd0; sdr = 64'h0000_0000_0000_00FF; valid = 1'b1;
        #1;
        check("rst_hist_sdr", e_sdr, 64'd0);
        check("rst_hist_dbi", 64'(e_dbi), 64'h01);
        step();
        check("rst_hist_cnt", 64'(e_cnt), 64'd1);
        idle(2);

        // Randomized traffic; configuration changes only after an idle gap
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                idle(2);
                stages = 2'($urandom_range(0, 3));
                ac     = 1'($urandom_range(0, 1));
                mask   = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            end
            valid   = ($urandom_range(0, 3) != 0);
            sdr     = {$urandom, $urandom};
            sdr_dbi = 8'($urandom);
            en      = ($urandom_range(0, 7) != 0);
            ones    = 1'($urandom_range(0, 1));
            clr     = ($urandom_range(0, 63) == 0);
            step();
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
